// File: rtl/fifo_rd_drain_ctrl_if.sv
// Handshake bundle for the FIFO read-side drain controller: FIFO pop port plus valid/ready slice stream.
// The controller uses the master modport; the FIFO and the downstream consumer sit on the slave side.
interface fifo_rd_drain_ctrl_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8
);
    logic                 fifo_empty;
    logic [IN_WIDTH-1:0]  fifo_rd_data;
    logic                 fifo_rd_inc;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_inc,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_inc,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fifo_rd_drain_ctrl.sv
// Pops FIFO words and streams them out as OUT_WIDTH slices, MSB slice first, with no bubble between words.
// Optional delivered-word counter is enabled by defining DRAIN_WORD_CNT_EN.
module fifo_rd_drain_ctrl #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8
`ifdef DRAIN_WORD_CNT_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_rd_drain_ctrl_if.master  bus,
    input  logic                  flush_i,
    output logic                  busy_o
`ifdef DRAIN_WORD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  word_cnt_o
`endif
);
    localparam int NSLICE = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  word_q, word_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 accept_last;
    logic                 pop;

    function automatic logic [OUT_WIDTH-1:0] slice_of(input logic [IN_WIDTH-1:0] w,
                                                      input logic [IDX_W-1:0]    k);
        return w[IN_WIDTH-1-int'(k)*OUT_WIDTH -: OUT_WIDTH];
    endfunction

    assign accept_last = (state_q == SEND) && out_valid_q && bus.out_ready && (idx_q == LAST_IDX);

    // NOTE: pop is Mealy so a waiting word is taken in the same cycle EMPTY falls; rst gates it
    // combinationally because the FIFO would otherwise see a pop while this block is held in reset.
    assign pop = !rst && !flush_i && !bus.fifo_empty && ((state_q == IDLE) || accept_last);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (flush_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            idx_d       = '0;
        end else if (pop) begin
            state_d     = SEND;
            word_d      = bus.fifo_rd_data;
            idx_d       = '0;
            out_data_d  = slice_of(bus.fifo_rd_data, '0);
            out_valid_d = 1'b1;
        end else if (state_q == SEND && out_valid_q && bus.out_ready) begin
            if (idx_q != LAST_IDX) begin
                idx_d      = idx_q + 1'b1;
                out_data_d = slice_of(word_q, idx_q + 1'b1);
            end else begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.fifo_rd_inc = pop;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign busy_o          = (state_q != IDLE);

`ifdef DRAIN_WORD_CNT_EN
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

    // Counts on acceptance of the final slice; a flush never clears it.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (accept_last) word_cnt_d = word_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) word_cnt_q <= '0;
        else     word_cnt_q <= word_cnt_d;
    end

    assign word_cnt_o = word_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rd_drain_ctrl.sv
// Directed bench for fifo_rd_drain_ctrl: per-cycle vector table plus reset and counter sequences.
// Define DRAIN_WORD_CNT_EN to also exercise the word counter with CNT_WIDTH=2.
module tb_fifo_rd_drain_ctrl;
    logic clk;
    logic rst;
    logic flush;
    logic busy;
`ifdef DRAIN_WORD_CNT_EN
    logic [1:0] word_cnt;
`endif

    fifo_rd_drain_ctrl_if #(.IN_WIDTH(16), .OUT_WIDTH(8)) bus ();

    fifo_rd_drain_ctrl #(
        .IN_WIDTH (16),
        .OUT_WIDTH(8)
`ifdef DRAIN_WORD_CNT_EN
        ,
        .CNT_WIDTH(2)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .flush_i(flush),
        .busy_o (busy)
`ifdef DRAIN_WORD_CNT_EN
        ,
        .word_cnt_o(word_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    always @(posedge clk) begin
        if (!rst && bus.fifo_rd_inc) pops <= pops + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        empty;
        logic [15:0] rd_data;
        logic        flush;
        logic        ready;
        logic        e_inc;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        chk_data;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic empty, input logic [15:0] rd, input logic fl, input logic rdy,
                       input logic inc, input logic vld, input logic [7:0] dat, input logic cd,
                       input logic bsy);
        vec_t v;
        v.empty = empty; v.rd_data = rd; v.flush = fl; v.ready = rdy;
        v.e_inc = inc; v.e_valid = vld; v.e_data = dat; v.chk_data = cd; v.e_busy = bsy;
        vecs.push_back(v);
    endtask

    initial begin
        // Each row: inputs held for one cycle; outputs expected before that cycle's rising edge.
        //   empty rd_data   fl rdy  inc vld data  chk bsy
        add(1, 16'h0000, 0, 1,   0,  0,  8'h00, 1, 0); // idle, no pop while empty
        add(0, 16'hA55A, 0, 1,   1,  0,  8'h00, 1, 0); // single word pop
        add(1, 16'h0000, 0, 1,   0,  1,  8'hA5, 1, 1);
        add(1, 16'h0000, 0, 1,   0,  1,  8'h5A, 1, 1);
        add(1, 16'h0000, 0, 1,   0,  0,  8'h00, 0, 0);
        add(0, 16'h1234, 0, 1,   1,  0,  8'h00, 0, 0); // back-to-back words
        add(0, 16'hABCD, 0, 1,   0,  1,  8'h12, 1, 1);
        add(0, 16'hABCD, 0, 1,   1,  1,  8'h34, 1, 1); // pop on last accept, no bubble
        add(1, 16'h0000, 0, 1,   0,  1,  8'hAB, 1, 1);
        add(1, 16'h0000, 0, 1,   0,  1,  8'hCD, 1, 1);
        add(1, 16'h0000, 0, 1,   0,  0,  8'h00, 0, 0);
        add(0, 16'h1234, 0, 0,   1,  0,  8'h00, 0, 0); // backpressure
        for (int i = 0; i < 5; i++)
            add(0, 16'h5678, 0, 0,   0,  1,  8'h12, 1, 1);
        add(0, 16'h5678, 0, 1,   0,  1,  8'h12, 1, 1);
        add(1, 16'h0000, 0, 0,   0,  1,  8'h34, 1, 1);
        add(1, 16'h0000, 0, 1,   0,  1,  8'h34, 1, 1);
        add(1, 16'h0000, 0, 1,   0,  0,  8'h00, 0, 0);
        add(0, 16'hBEEF, 0, 0,   1,  0,  8'h00, 0, 0); // flush during slice 0
        add(0, 16'h1111, 1, 0,   0,  1,  8'hBE, 1, 1);
        add(0, 16'h1111, 1, 0,   0,  0,  8'h00, 0, 0);
        add(0, 16'h1111, 0, 1,   1,  0,  8'h00, 0, 0); // pop resumes after flush
        add(1, 16'h0000, 0, 1,   0,  1,  8'h11, 1, 1);
        add(1, 16'h0000, 0, 1,   0,  1,  8'h11, 1, 1);
        add(1, 16'h0000, 0, 1,   0,  0,  8'h00, 0, 0);

        rst = 1'b1;
        flush = 1'b0;
        bus.fifo_empty = 1'b0;
        bus.fifo_rd_data = 16'hFFFF;
        bus.out_ready = 1'b1;
        #2;
        check("reset_inc",   32'(bus.fifo_rd_inc), 32'd0);
        check("reset_valid", 32'(bus.out_valid),   32'd0);
        check("reset_data",  32'(bus.out_data),    32'd0);
        check("reset_busy",  32'(busy),            32'd0);

        @(negedge clk);
        bus.fifo_empty = 1'b1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.fifo_empty   = vecs[i].empty;
            bus.fifo_rd_data = vecs[i].rd_data;
            flush            = vecs[i].flush;
            bus.out_ready    = vecs[i].ready;
            #1;
            check($sformatf("row%0d_inc", i),   32'(bus.fifo_rd_inc), 32'(vecs[i].e_inc));
            check($sformatf("row%0d_valid", i), 32'(bus.out_valid),   32'(vecs[i].e_valid));
            check($sformatf("row%0d_busy", i),  32'(busy),            32'(vecs[i].e_busy));
            if (vecs[i].chk_data)
                check($sformatf("row%0d_data", i), 32'(bus.out_data), 32'(vecs[i].e_data));
        end

        check("total_pops", 32'(pops), 32'd6);
`ifdef DRAIN_WORD_CNT_EN
        // Five delivered words (flushed 0xBEEF excluded) wrap a 2-bit counter to 1.
        check("word_cnt_wrap", 32'(word_cnt), 32'd1);
`endif

        // Reset mid-word: outputs clear asynchronously and pop stays low while rst is high.
        @(negedge clk);
        bus.fifo_empty   = 1'b0;
        bus.fifo_rd_data = 16'hC3C3;
        bus.out_ready    = 1'b0;
        @(negedge clk);
        bus.fifo_empty = 1'b0;
        #1;
        check("midword_valid", 32'(bus.out_valid), 32'd1);
        check("midword_data",  32'(bus.out_data),  32'hC3);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(bus.out_valid),   32'd0);
        check("rst_mid_data",  32'(bus.out_data),    32'd0);
        check("rst_mid_busy",  32'(busy),            32'd0);
        check("rst_mid_inc",   32'(bus.fifo_rd_inc), 32'd0);
`ifdef DRAIN_WORD_CNT_EN
        check("rst_word_cnt",  32'(word_cnt),        32'd0);
`endif
        @(negedge clk);
        check("rst_held_inc",  32'(bus.fifo_rd_inc), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_inc",  32'(bus.fifo_rd_inc), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
